rvfi_trace_fifo: RTL and testbench

Multi-port RVFI trace buffer between the RVFI packer's per-commit-port retire records and a single-lane trace sink (DPI logger, off-chip trace port). Each cycle it accepts up to NrPorts retire records, filters them by privilege mode, and tags each with a 64-bit retire order number. It compacts them in program order (port 0 oldest) into a FIFO and streams one record per cycle on a valid/ready interface. Overflow never stalls the core: whole commit groups are dropped, counted and flagged so the sink sees an explicit gap.

---
 rtl/rvfi_trace_pkg.sv | 24 ++
 rtl/rvfi_trace_compact.sv | 50 +++++
 rtl/rvfi_trace_fifo.sv | 164 ++++++++++++++++
 tb/tb_rvfi_trace_fifo.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_trace_pkg.sv
// Shared constants and helpers for the RVFI trace buffer: privilege mode
// encodings, order-number width and a port-valid popcount.
package rvfi_trace_pkg;

  localparam int unsigned OrderWidth = 64;
  localparam int unsigned MaxPorts   = 4;

  typedef logic [1:0] mode_t;

  localparam mode_t ModeU = 2'd0;
  localparam mode_t ModeS = 2'd1;
  localparam mode_t ModeD = 2'd2;
  localparam mode_t ModeM = 2'd3;

  function automatic logic [2:0] popcount_ports(input logic [MaxPorts-1:0] bits);
    logic [2:0] cnt;
    cnt = '0;
    for (int i = 0; i < MaxPorts; i++) begin
      cnt = cnt + {2'b00, bits[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/rvfi_trace_compact.sv
// Combinational compaction of kept commit ports onto lanes 0..K-1 in port
// order, plus the order offset of each record within its commit group.
module rvfi_trace_compact
  import rvfi_trace_pkg::*;
#(
  parameter int unsigned NrPorts = 2,
  parameter int unsigned PortW   = (NrPorts > 1) ? $clog2(NrPorts) : 1,
  parameter int unsigned CntW    = $clog2(NrPorts + 1)
) (
  input  logic [NrPorts-1:0]            valid_i,
  input  logic [NrPorts-1:0]            keep_i,
  output logic [NrPorts-1:0]            lane_valid_o,
  output logic [NrPorts-1:0][PortW-1:0] lane_port_o,
  output logic [NrPorts-1:0][CntW-1:0]  lane_offset_o,
  output logic [CntW-1:0]               kept_cnt_o
);

  logic [NrPorts-1:0][CntW-1:0] keep_pre;
  logic [NrPorts-1:0][CntW-1:0] valid_pre;

  // Exclusive prefix counts: keep_pre[p] is the lane port p lands on,
  // valid_pre[p] is its order offset inside the group.
  always_comb begin
    keep_pre  = '0;
    valid_pre = '0;
    for (int p = 1; p < NrPorts; p++) begin
      keep_pre[p]  = keep_pre[p-1]  + CntW'(keep_i[p-1]);
      valid_pre[p] = valid_pre[p-1] + CntW'(valid_i[p-1]);
    end
    kept_cnt_o = keep_pre[NrPorts-1] + CntW'(keep_i[NrPorts-1]);
  end

  // NOTE: every output gets a default before the loops so no path leaves a
  // value unassigned; without that this block would infer latches.
  always_comb begin
    lane_valid_o  = '0;
    lane_port_o   = '0;
    lane_offset_o = '0;
    for (int l = 0; l < NrPorts; l++) begin
      for (int p = 0; p < NrPorts; p++) begin
        if (keep_i[p] && (keep_pre[p] == CntW'(l))) begin
          lane_valid_o[l]  = 1'b1;
          lane_port_o[l]   = PortW'(p);
          lane_offset_o[l] = valid_pre[p];
        end
      end
    end
  end

endmodule

// File: rtl/rvfi_trace_fifo.sv
// Multi-port RVFI trace buffer: filters and tags retire records, compacts them
// into a FIFO and streams one per cycle; overflow drops whole commit groups.
module rvfi_trace_fifo
  import rvfi_trace_pkg::*;
#(
  parameter  int unsigned NrPorts   = 2,
  parameter  int unsigned DataWidth = 512,
  parameter  int unsigned Depth     = 8,
  parameter  int unsigned CntWidth  = 32,
  localparam int unsigned PortW     = (NrPorts > 1) ? $clog2(NrPorts) : 1,
  localparam int unsigned PtrW      = $clog2(Depth),
  localparam int unsigned OccW      = $clog2(Depth) + 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NrPorts-1:0]                commit_valid_i,
  input  logic [NrPorts-1:0][DataWidth-1:0] commit_data_i,
  input  logic [NrPorts-1:0][1:0]           commit_mode_i,
  input  logic                              trace_en_i,
  input  logic [3:0]                        mode_mask_i,
  input  logic                              ovf_clear_i,
  output logic                              trace_valid_o,
  input  logic                              trace_ready_i,
  output logic [DataWidth-1:0]              trace_data_o,
  output logic [OrderWidth-1:0]             trace_order_o,
  output logic [PortW-1:0]                  trace_port_o,
  output logic                              trace_gap_o,
  output logic [OccW-1:0]                   count_o,
  output logic                              overflow_o,
  output logic [CntWidth-1:0]               drop_cnt_o
);

  localparam int unsigned CntW = $clog2(NrPorts + 1);
  localparam int unsigned SumW = CntWidth + 1;

  typedef struct packed {
    logic [DataWidth-1:0]  data;
    logic [OrderWidth-1:0] order;
    logic [PortW-1:0]      port;
    logic                  gap;
  } entry_t;

  logic [NrPorts-1:0]            keep;
  logic [NrPorts-1:0]            lane_valid;
  logic [NrPorts-1:0][PortW-1:0] lane_port;
  logic [NrPorts-1:0][CntW-1:0]  lane_offset;
  logic [CntW-1:0]               kept_cnt;
  entry_t                        lane_entry [NrPorts];

  entry_t                  mem_q [Depth];
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]         count_q, count_d;
  logic [OrderWidth-1:0]   order_q, order_d;
  logic                    overflow_q, overflow_d;
  logic [CntWidth-1:0]     drop_cnt_q, drop_cnt_d;
  logic                    gap_pending_q, gap_pending_d;

  logic                    any_kept, accept, drop, pop;
  logic [OccW-1:0]         free_slots;
  logic [CntWidth-1:0]     drop_base;
  logic [SumW-1:0]         drop_sum;

  always_comb begin
    for (int p = 0; p < NrPorts; p++) begin
      keep[p] = commit_valid_i[p] && trace_en_i && mode_mask_i[commit_mode_i[p]];
    end
  end

  rvfi_trace_compact #(
    .NrPorts (NrPorts),
    .PortW   (PortW),
    .CntW    (CntW)
  ) u_compact (
    .valid_i       (commit_valid_i),
    .keep_i        (keep),
    .lane_valid_o  (lane_valid),
    .lane_port_o   (lane_port),
    .lane_offset_o (lane_offset),
    .kept_cnt_o    (kept_cnt)
  );

  always_comb begin
    for (int l = 0; l < NrPorts; l++) begin
      lane_entry[l].data  = commit_data_i[lane_port[l]];
      lane_entry[l].order = order_q + OrderWidth'(lane_offset[l]);
      lane_entry[l].port  = lane_port[l];
      lane_entry[l].gap   = (l == 0) ? gap_pending_q : 1'b0;
    end
  end

  // NOTE: combinational next-state logic uses blocking '=' so later lines see
  // earlier results; the registers below use '<=' so all update together.
  always_comb begin
    free_slots    = OccW'(Depth) - count_q;
    any_kept      = (kept_cnt != '0);
    accept        = any_kept && (OccW'(kept_cnt) <= free_slots);
    drop          = any_kept && !accept;
    pop           = (count_q != '0) && trace_ready_i;

    wr_ptr_d      = accept ? wr_ptr_q + PtrW'(kept_cnt) : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d       = count_q + (accept ? OccW'(kept_cnt) : '0) - (pop ? OccW'(1) : '0);
    order_d       = order_q + OrderWidth'(popcount_ports(MaxPorts'(commit_valid_i)));

    drop_base     = ovf_clear_i ? '0 : drop_cnt_q;
    drop_sum      = {1'b0, drop_base} + SumW'(kept_cnt);
    overflow_d    = overflow_q;
    drop_cnt_d    = drop_cnt_q;
    gap_pending_d = gap_pending_q;

    if (drop) begin
      overflow_d    = 1'b1;
      drop_cnt_d    = drop_sum[CntWidth] ? '1 : drop_sum[CntWidth-1:0];
      gap_pending_d = 1'b1;
    end else begin
      if (ovf_clear_i) begin
        overflow_d = 1'b0;
        drop_cnt_d = '0;
      end
      if (accept) gap_pending_d = 1'b0;
    end
  end

  // NOTE: the storage array is reset along with the pointers so the trace
  // outputs read as zero after reset rather than stale or X contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      order_q       <= '0;
      overflow_q    <= 1'b0;
      drop_cnt_q    <= '0;
      gap_pending_q <= 1'b0;
    end else begin
      if (accept) begin
        for (int l = 0; l < NrPorts; l++) begin
          if (lane_valid[l]) mem_q[wr_ptr_q + PtrW'(l)] <= lane_entry[l];
        end
      end
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      order_q       <= order_d;
      overflow_q    <= overflow_d;
      drop_cnt_q    <= drop_cnt_d;
      gap_pending_q <= gap_pending_d;
    end
  end

  entry_t head;
  assign head          = mem_q[rd_ptr_q];
  assign trace_valid_o = (count_q != '0);
  assign trace_data_o  = head.data;
  assign trace_order_o = head.order;
  assign trace_port_o  = head.port;
  assign trace_gap_o   = head.gap;
  assign count_o       = count_q;
  assign overflow_o    = overflow_q;
  assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_rvfi_trace_fifo.sv
// Directed and scoreboard-checked stimulus for rvfi_trace_fifo with
// NrPorts=2, Depth=8.
module tb_rvfi_trace_fifo;
  import rvfi_trace_pkg::*;

  localparam int NrPorts   = 2;
  localparam int DataWidth = 512;
  localparam int Depth     = 8;
  localparam int CntWidth  = 32;

  logic                              clk = 1'b0;
  logic                              rst_i;
  logic [NrPorts-1:0]                commit_valid_i;
  logic [NrPorts-1:0][DataWidth-1:0] commit_data_i;
  logic [NrPorts-1:0][1:0]           commit_mode_i;
  logic                              trace_en_i;
  logic [3:0]                        mode_mask_i;
  logic                              ovf_clear_i;
  logic                              trace_valid_o;
  logic                              trace_ready_i;
  logic [DataWidth-1:0]              trace_data_o;
  logic [63:0]                       trace_order_o;
  logic [0:0]                        trace_port_o;
  logic                              trace_gap_o;
  logic [3:0]                        count_o;
  logic                              overflow_o;
  logic [CntWidth-1:0]               drop_cnt_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rvfi_trace_fifo #(
    .NrPorts   (NrPorts),
    .DataWidth (DataWidth),
    .Depth     (Depth),
    .CntWidth  (CntWidth)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .commit_valid_i (commit_valid_i),
    .commit_data_i  (commit_data_i),
    .commit_mode_i  (commit_mode_i),
    .trace_en_i     (trace_en_i),
    .mode_mask_i    (mode_mask_i),
    .ovf_clear_i    (ovf_clear_i),
    .trace_valid_o  (trace_valid_o),
    .trace_ready_i  (trace_ready_i),
    .trace_data_o   (trace_data_o),
    .trace_order_o  (trace_order_o),
    .trace_port_o   (trace_port_o),
    .trace_gap_o    (trace_gap_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o),
    .drop_cnt_o     (drop_cnt_o)
  );

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [63:0]          order;
    logic                 port;
    logic                 gap;
  } exp_t;

  exp_t        model_q[$];
  logic [63:0] m_order;
  logic        m_ovf;
  logic [31:0] m_drop;
  logic        m_gap;

  task automatic check(input string tag, input logic [DataWidth-1:0] obs,
                       input logic [DataWidth-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DataWidth-1:0] mk_data(input logic [63:0] ord);
    return {8{ord ^ 64'hA5A5_0000_0000_0000}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [63:0] base);
    commit_valid_i   = v;
    commit_data_i[0] = mk_data(base);
    commit_data_i[1] = mk_data(base + {63'b0, v[0]});
  endtask

  task automatic check_head(input string tag, input logic [63:0] ord,
                            input logic port, input logic gap);
    check({tag, "_valid"}, trace_valid_o, 1'b1);
    check({tag, "_order"}, trace_order_o, ord);
    check({tag, "_port"},  trace_port_o, port);
    check({tag, "_gap"},   trace_gap_o, gap);
    check({tag, "_data"},  trace_data_o, mk_data(ord));
  endtask

  task automatic compare_model();
    check("soak_valid", trace_valid_o, model_q.size() != 0);
    check("soak_count", count_o, model_q.size());
    check("soak_ovf",   overflow_o, m_ovf);
    check("soak_drop",  drop_cnt_o, m_drop);
    if (model_q.size() != 0) begin
      check("soak_data",  trace_data_o,  model_q[0].data);
      check("soak_order", trace_order_o, model_q[0].order);
      check("soak_port",  trace_port_o,  model_q[0].port);
      check("soak_gap",   trace_gap_o,   model_q[0].gap);
    end
  endtask

  initial begin
    logic [63:0] t4_ord [7];
    logic        t4_port[7];
    logic        t4_gap [7];
    exp_t        kept[$];
    exp_t        e;
    logic [1:0]  v;
    logic [32:0] sum;
    logic        rdy, clr, en;
    logic [3:0]  mask;

    rst_i          = 1'b1;
    commit_valid_i = '0;
    commit_data_i  = '0;
    commit_mode_i  = {ModeM, ModeM};
    trace_en_i     = 1'b1;
    mode_mask_i    = 4'hF;
    ovf_clear_i    = 1'b0;
    trace_ready_i  = 1'b0;
    step();
    step();

    // Reset state
    check("rst_valid", trace_valid_o, 1'b0);
    check("rst_count", count_o, 4'd0);
    check("rst_ovf",   overflow_o, 1'b0);
    check("rst_drop",  drop_cnt_o, 32'd0);
    check("rst_order", trace_order_o, 64'd0);
    check("rst_data",  trace_data_o, '0);
    check("rst_port",  trace_port_o, 1'b0);
    check("rst_gap",   trace_gap_o, 1'b0);
    rst_i = 1'b0;

    // T1: three full groups, then drain in program order
    for (int c = 0; c < 3; c++) begin
      drive(2'b11, 64'(2 * c));
      step();
    end
    drive(2'b00, 0);
    check("t1_count6", count_o, 4'd6);
    trace_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check_head("t1_pop", 64'(i), 1'(i % 2), 1'b0);
      step();
    end
    trace_ready_i = 1'b0;
    check("t1_empty_count", count_o, 4'd0);
    check("t1_empty_valid", trace_valid_o, 1'b0);

    // T2: port 1 only; order counter is 6
    drive(2'b10, 6);
    step();
    drive(2'b00, 0);
    check("t2_count", count_o, 4'd1);
    check_head("t2", 64'd6, 1'b1, 1'b0);
    trace_ready_i = 1'b1;
    step();
    trace_ready_i = 1'b0;
    check("t2_drained", count_o, 4'd0);

    // T3: mode filter keeps only M; counter 7 -> 9
    mode_mask_i      = 4'b1000;
    commit_mode_i[0] = ModeU;
    commit_mode_i[1] = ModeM;
    drive(2'b11, 7);
    step();
    drive(2'b00, 0);
    mode_mask_i   = 4'hF;
    commit_mode_i = {ModeM, ModeM};
    check("t3_count", count_o, 4'd1);
    check_head("t3_filt", 64'd8, 1'b1, 1'b0);
    drive(2'b01, 9);
    step();
    drive(2'b00, 0);
    check("t3_count2", count_o, 4'd2);
    trace_ready_i = 1'b1;
    check_head("t3_a", 64'd8, 1'b1, 1'b0);
    step();
    check_head("t3_b", 64'd9, 1'b0, 1'b0);
    step();
    trace_ready_i = 1'b0;
    check("t3_drained", count_o, 4'd0);

    // T4: fill to 7, group of 2 dropped, gap marking, full+pop drop
    for (int c = 0; c < 3; c++) begin
      drive(2'b11, 64'(10 + 2 * c));
      step();
    end
    drive(2'b01, 16);
    step();
    check("t4_count7", count_o, 4'd7);
    drive(2'b11, 17);
    step();
    drive(2'b00, 0);
    check("t4_drop_count", count_o, 4'd7);
    check("t4_drop_cnt", drop_cnt_o, 32'd2);
    check("t4_ovf", overflow_o, 1'b1);
    trace_ready_i = 1'b1;
    step();
    trace_ready_i = 1'b0;
    check("t4_count6", count_o, 4'd6);
    drive(2'b11, 19);
    step();
    check("t4_count8", count_o, 4'd8);
    drive(2'b11, 21);
    trace_ready_i = 1'b1;
    step();
    drive(2'b00, 0);
    trace_ready_i = 1'b0;
    check("t4_fullpop_count", count_o, 4'd7);
    check("t4_fullpop_drop", drop_cnt_o, 32'd4);
    t4_ord  = '{64'd12, 64'd13, 64'd14, 64'd15, 64'd16, 64'd19, 64'd20};
    t4_port = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    t4_gap  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    trace_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check_head("t4_pop", t4_ord[i], t4_port[i], t4_gap[i]);
      step();
    end
    trace_ready_i = 1'b0;
    check("t4_drained", count_o, 4'd0);

    // T5: gap from full+pop drop, then drop with simultaneous clear
    drive(2'b11, 23);
    step();
    check_head("t5_gap", 64'd23, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      drive(2'b11, 64'(25 + 2 * c));
      step();
    end
    check("t5_full", count_o, 4'd8);
    drive(2'b11, 31);
    ovf_clear_i = 1'b1;
    step();
    drive(2'b00, 0);
    check("t5_clr_drop_cnt", drop_cnt_o, 32'd2);
    check("t5_clr_drop_ovf", overflow_o, 1'b1);
    step();
    ovf_clear_i = 1'b0;
    check("t5_clr_cnt", drop_cnt_o, 32'd0);
    check("t5_clr_ovf", overflow_o, 1'b0);

    // T6: pop to 5 entries, then reset mid-stream
    trace_ready_i = 1'b1;
    check_head("t6_a", 64'd23, 1'b0, 1'b1);
    step();
    check_head("t6_b", 64'd24, 1'b1, 1'b0);
    step();
    check_head("t6_c", 64'd25, 1'b0, 1'b0);
    step();
    trace_ready_i = 1'b0;
    check("t6_count5", count_o, 4'd5);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("t6_rst_valid", trace_valid_o, 1'b0);
    check("t6_rst_count", count_o, 4'd0);
    check("t6_rst_order", trace_order_o, 64'd0);
    drive(2'b01, 0);
    step();
    drive(2'b00, 0);
    check_head("t6_restart", 64'd0, 1'b0, 1'b0);

    // Random soak against the scoreboard
    rst_i = 1'b1;
    step();
    rst_i   = 1'b0;
    model_q = {};
    m_order = '0;
    m_ovf   = 1'b0;
    m_drop  = '0;
    m_gap   = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      compare_model();
      v    = 2'($urandom_range(0, 3));
      en   = ($urandom_range(0, 9) != 0);
      mask = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      rdy  = ($urandom_range(0, 9) < 4);
      clr  = ($urandom_range(0, 15) == 0);
      for (int p = 0; p < NrPorts; p++) begin
        commit_mode_i[p] = 2'($urandom_range(0, 3));
        commit_data_i[p] = {16{$urandom()}};
      end
      commit_valid_i = v;
      trace_en_i     = en;
      mode_mask_i    = mask;
      trace_ready_i  = rdy;
      ovf_clear_i    = clr;

      kept = {};
      for (int p = 0; p < NrPorts; p++) begin
        if (v[p] && en && mask[commit_mode_i[p]]) begin
          e.data  = commit_data_i[p];
          e.order = m_order + ((p == 1 && v[0]) ? 64'd1 : 64'd0);
          e.port  = 1'(p);
          e.gap   = 1'b0;
          kept.push_back(e);
        end
      end
      if (kept.size() != 0 && kept.size() <= Depth - model_q.size()) begin
        if (rdy && model_q.size() != 0) void'(model_q.pop_front());
        kept[0].gap = m_gap;
        m_gap = 1'b0;
        foreach (kept[i]) model_q.push_back(kept[i]);
        if (clr) begin m_ovf = 1'b0; m_drop = '0; end
      end else begin
        if (rdy && model_q.size() != 0) void'(model_q.pop_front());
        if (kept.size() != 0) begin
          m_ovf = 1'b1;
          sum   = {1'b0, (clr ? 32'd0 : m_drop)} + 33'(kept.size());
          m_drop = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
          m_gap = 1'b1;
        end else if (clr) begin
          m_ovf  = 1'b0;
          m_drop = '0;
        end
      end
      m_order = m_order + 64'(v[0]) + 64'(v[1]);
      step();
    end
    compare_model();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
